// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes
// and the select/control codes driven onto the datapath.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  // Which instruction class the ALU decoder is interpreting this cycle
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_BRANCH, ALUOP_R, ALUOP_I} aluop_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory port: req/ready handshake plus address select.
// The request stays asserted with a stable address until mem_ready is seen.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU control decode from instruction class, funct3 and funct7[5].
// Zero latency; no handshake. legal=0 flags encodings the datapath cannot execute.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (aluop)
      ALUOP_BRANCH: begin
        alu_ctrl = ALU_SUB;
        legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
      end
      ALUOP_R, ALUOP_I: begin
        case (funct3)
          3'b000:  alu_ctrl = (aluop == ALUOP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          3'b010:  alu_ctrl = ALU_SLT;
          default: legal = 1'b0;
        endcase
        // Only add/sub is distinguished by funct7 in R-type
        if (aluop == ALUOP_R && funct7b5 && funct3 != 3'b000) begin
          legal = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of a multi-cycle RV32I datapath: fetch/decode/execute/memory/writeback.
// Latency 3-5 cycles per instruction; FETCH/MEMREAD/MEMWRITE stall while mem_ready=0.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master mem,
  input  logic [DATA_WIDTH-1:0]   instr,
  input  logic                    zero,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    reg_write,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [2:0]              alu_ctrl,
  output logic [1:0]              imm_src,
  output logic [1:0]              result_src,
  output logic                    illegal,
  output logic [DATA_WIDTH-1:0]   instret
);

  state_t                state, state_n;
  logic                  illegal_q;
  logic [DATA_WIDTH-1:0] instret_q;
  logic                  retire;
  aluop_t                aluop;
  logic [2:0]            dec_ctrl;
  logic                  dec_legal;
  logic                  unused_instr_bits;

  wire [6:0] opcode = instr[6:0];
  wire [2:0] funct3 = instr[14:12];

  assign unused_instr_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

  always_comb begin
    case (state)
      S_EXECR:  aluop = ALUOP_R;
      S_EXECI:  aluop = ALUOP_I;
      S_BRANCH: aluop = ALUOP_BRANCH;
      default:  aluop = ALUOP_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop    (aluop),
    .funct3   (funct3),
    .funct7b5 (instr[30]),
    .alu_ctrl (dec_ctrl),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state <= state_n;
      if (state_n == S_TRAP) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        instret_q <= instret_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    state_n       = state;
    retire        = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_write = 1'b0;
    mem.adr_src   = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REG;
    alu_ctrl      = ALU_ADD;
    imm_src       = IMM_I;
    result_src    = RES_ALUOUT;
    case (state)
      S_RESET: state_n = S_FETCH;
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALURES;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_n  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jump target is computed here so BRANCH/JAL can use ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_R:         state_n = S_EXECR;
          OP_I:         state_n = S_EXECI;
          OP_BR:        state_n = S_BRANCH;
          OP_JAL:       state_n = S_JAL;
          default:      state_n = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_SW) begin
          imm_src = IMM_S;
          state_n = S_MEMWRITE;
        end else begin
          imm_src = IMM_I;
          state_n = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        mem.mem_req = 1'b1;
        mem.adr_src = 1'b1;
        if (mem.mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_DATA;
        retire     = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem.mem_req   = 1'b1;
        mem.mem_write = 1'b1;
        mem.adr_src   = 1'b1;
        if (mem.mem_ready) begin
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = (state == S_EXECI) ? SRCB_IMM : SRCB_REG;
        imm_src   = IMM_I;
        alu_ctrl  = dec_ctrl;
        state_n   = dec_legal ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        retire     = 1'b1;
        state_n    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        alu_ctrl   = dec_ctrl;
        result_src = RES_ALUOUT;
        if (dec_legal) begin
          pc_write = funct3[0] ? ~zero : zero;
          retire   = 1'b1;
          state_n  = S_FETCH;
        end else begin
          state_n  = S_TRAP;
        end
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd
        pc_write   = 1'b1;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        state_n    = S_ALUWB;
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_RESET;
    endcase
  end

  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each scenario queues per-cycle stimulus and expected outputs,
// then drains the queues cycle by cycle against the controller.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] a, b;
    logic [2:0] ctrl;
    logic [1:0] imm, rs;
    logic       ill;
  } ov_t;

  typedef struct packed {
    logic [31:0] ins;
    logic        mr;
    logic        z;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        ir_write, pc_write, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0]  alu_ctrl;
  logic [31:0] instret;
  ov_t         obs;
  ov_t         exp_q[$];
  stim_t       stim_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_instret = '0;

  multicycle_controller_if mif();

  multicycle_controller #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (mif),
    .instr      (instr),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .imm_src    (imm_src),
    .result_src (result_src),
    .illegal    (illegal),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  assign obs = {mif.mem_req, mif.mem_write, mif.adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, illegal};

  // Expected output vectors per state, written from the control table
  function automatic ov_t v(input logic req, wr, adr, irw, pcw, rw,
                            input logic [1:0] a, b, input logic [2:0] c,
                            input logic [1:0] imm, rs, input logic ill);
    return {req, wr, adr, irw, pcw, rw, a, b, c, imm, rs, ill};
  endfunction
  function automatic ov_t v_fetch(input logic rdy);
    return v(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 0);
  endfunction
  function automatic ov_t v_decode(input logic [1:0] imm);
    return v(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, imm, 2'b00, 0);
  endfunction
  function automatic ov_t v_memadr(input logic [1:0] imm);
    return v(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, imm, 2'b00, 0);
  endfunction
  function automatic ov_t v_memread();
    return v(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
  endfunction
  function automatic ov_t v_memwb();
    return v(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 2'b01, 0);
  endfunction
  function automatic ov_t v_memwrite();
    return v(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
  endfunction
  function automatic ov_t v_execr(input logic [2:0] c);
    return v(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, c, 2'b00, 2'b00, 0);
  endfunction
  function automatic ov_t v_execi(input logic [2:0] c);
    return v(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, c, 2'b00, 2'b00, 0);
  endfunction
  function automatic ov_t v_aluwb();
    return v(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
  endfunction
  function automatic ov_t v_branch(input logic pcw);
    return v(0, 0, 0, 0, pcw, 0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 0);
  endfunction
  function automatic ov_t v_jal();
    return v(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 3'b000, 2'b00, 2'b00, 0);
  endfunction
  function automatic ov_t v_trap();
    return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1);
  endfunction

  task automatic push(input logic [31:0] ins, input logic mr, input logic z, input ov_t e);
    stim_q.push_back({ins, mr, z});
    exp_q.push_back(e);
  endtask

  task automatic drive_cycle(input stim_t s, output ov_t got);
    @(negedge clk);
    instr         = s.ins;
    mif.mem_ready = s.mr;
    zero          = s.z;
    #1;
    got = obs;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = '0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_async outs=%h exp=0", obs); end
    checks++;
    if (instret !== 32'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_state outs=%h exp=0", obs); end
  endtask

  task automatic test_addi();
    ov_t got, e;
    int  n = 0;
    push(32'h00500093, 1, 0, v_fetch(1));
    push(32'h00500093, 1, 0, v_decode(2'b10));
    push(32'h00500093, 1, 0, v_execi(3'b000));
    push(32'h00500093, 1, 0, v_aluwb());
    while (exp_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), got);
      e = exp_q.pop_front(); n++; checks++;
      if (got !== e) begin failures++; $display("FAIL addi cyc%0d got=%h exp=%h", n, got, e); end
    end
    exp_instret++;
    @(posedge clk); #1;
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL addi_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_lw_stall();
    ov_t got, e;
    int  n = 0;
    for (int i = 0; i < 3; i++) push(32'h00002083, 0, 0, v_fetch(0));
    push(32'h00002083, 1, 0, v_fetch(1));
    push(32'h00002083, 1, 0, v_decode(2'b10));
    push(32'h00002083, 1, 0, v_memadr(2'b00));
    for (int i = 0; i < 3; i++) push(32'h00002083, 0, 0, v_memread());
    push(32'h00002083, 1, 0, v_memread());
    push(32'h00002083, 0, 0, v_memwb());
    while (exp_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), got);
      e = exp_q.pop_front(); n++; checks++;
      if (got !== e) begin failures++; $display("FAIL lw_stall cyc%0d got=%h exp=%h", n, got, e); end
    end
    exp_instret++;
    @(posedge clk); #1;
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL lw_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_sw();
    ov_t got, e;
    int  n = 0;
    push(32'h00102223, 1, 0, v_fetch(1));
    push(32'h00102223, 1, 0, v_decode(2'b10));
    push(32'h00102223, 1, 0, v_memadr(2'b01));
    push(32'h00102223, 1, 0, v_memwrite());
    while (exp_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), got);
      e = exp_q.pop_front(); n++; checks++;
      if (got !== e) begin failures++; $display("FAIL sw cyc%0d got=%h exp=%h", n, got, e); end
    end
    exp_instret++;
    @(posedge clk); #1;
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL sw_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_back_to_back();
    ov_t         got, e;
    int          n = 0;
    logic [31:0] ins  [6] = '{32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                              32'h0020A1B3, 32'h4000E193, 32'h0050A193};
    logic        is_r [6] = '{1, 1, 1, 1, 0, 0};
    logic [2:0]  ctl  [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b011, 3'b101};
    for (int i = 0; i < 6; i++) begin
      push(ins[i], 1, 0, v_fetch(1));
      push(ins[i], 1, 0, v_decode(2'b10));
      push(ins[i], 1, 0, is_r[i] ? v_execr(ctl[i]) : v_execi(ctl[i]));
      push(ins[i], 1, 0, v_aluwb());
    end
    while (exp_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), got);
      e = exp_q.pop_front(); n++; checks++;
      if (got !== e) begin failures++; $display("FAIL alu_ops cyc%0d got=%h exp=%h", n, got, e); end
    end
    exp_instret += 6;
    @(posedge clk); #1;
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL alu_ops_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_bne();
    ov_t got, e;
    int  n = 0;
    push(32'h00209463, 1, 0, v_fetch(1));
    push(32'h00209463, 1, 0, v_decode(2'b10));
    push(32'h00209463, 1, 0, v_branch(1));
    push(32'h00209463, 1, 1, v_fetch(1));
    push(32'h00209463, 1, 1, v_decode(2'b10));
    push(32'h00209463, 1, 1, v_branch(0));
    while (exp_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), got);
      e = exp_q.pop_front(); n++; checks++;
      if (got !== e) begin failures++; $display("FAIL bne cyc%0d got=%h exp=%h", n, got, e); end
    end
    exp_instret += 2;
    @(posedge clk); #1;
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL bne_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_jal();
    ov_t got, e;
    int  n = 0;
    push(32'h008000EF, 1, 0, v_fetch(1));
    push(32'h008000EF, 1, 0, v_decode(2'b11));
    push(32'h008000EF, 1, 0, v_jal());
    push(32'h008000EF, 1, 0, v_aluwb());
    while (exp_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), got);
      e = exp_q.pop_front(); n++; checks++;
      if (got !== e) begin failures++; $display("FAIL jal cyc%0d got=%h exp=%h", n, got, e); end
    end
    exp_instret++;
    @(posedge clk); #1;
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL jal_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_reset_mid_memread();
    ov_t got, e;
    int  n = 0;
    push(32'h00002083, 1, 0, v_fetch(1));
    push(32'h00002083, 1, 0, v_decode(2'b10));
    push(32'h00002083, 1, 0, v_memadr(2'b00));
    push(32'h00002083, 0, 0, v_memread());
    push(32'h00002083, 0, 0, v_memread());
    while (exp_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), got);
      e = exp_q.pop_front(); n++; checks++;
      if (got !== e) begin failures++; $display("FAIL rst_mid cyc%0d got=%h exp=%h", n, got, e); end
    end
    rst_n = 1'b0;
    #1;
    exp_instret = '0;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL rst_mid_outs got=%h exp=0", obs); end
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL rst_mid_instret got=%0d exp=0", instret); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_trap_opcode();
    ov_t got, e;
    int  n = 0;
    push(32'h0000007F, 1, 0, v_fetch(1));
    push(32'h0000007F, 1, 0, v_decode(2'b10));
    for (int i = 0; i < 4; i++) push(32'h0000007F, i[0], 0, v_trap());
    while (exp_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), got);
      e = exp_q.pop_front(); n++; checks++;
      if (got !== e) begin failures++; $display("FAIL trap_op cyc%0d got=%h exp=%h", n, got, e); end
    end
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL trap_op_instret got=%0d exp=%0d", instret, exp_instret); end
    apply_reset();
  endtask

  task automatic test_trap_rtype();
    ov_t got, e;
    int  n = 0;
    push(32'h002090B3, 1, 0, v_fetch(1));
    push(32'h002090B3, 1, 0, v_decode(2'b10));
    push(32'h002090B3, 1, 0, v_execr(3'b000));
    for (int i = 0; i < 3; i++) push(32'h002090B3, 1, 0, v_trap());
    while (exp_q.size() > 0) begin
      drive_cycle(stim_q.pop_front(), got);
      e = exp_q.pop_front(); n++; checks++;
      if (got !== e) begin failures++; $display("FAIL trap_r cyc%0d got=%h exp=%h", n, got, e); end
    end
    checks++;
    if (instret !== exp_instret) begin failures++; $display("FAIL trap_r_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_lw_stall();
    test_sw();
    test_back_to_back();
    test_bne();
    test_jal();
    test_reset_mid_memread();
    test_addi();
    test_trap_opcode();
    test_trap_rtype();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Clocked main FSM that sequences a multi-cycle RV32I datapath: fetch, decode, execute, memory, writeback.
- Drives the mux selects and write enables of a shared ALU, register file, instruction/data memory port, PC and internal registers (IR, OldPC, ALUOut, Data).
- Replaces the single-cycle combinational decoder.
- Memory is a single shared port with a req/ready handshake.

Parameters:
- DATA_WIDTH, 32, instruction and counter width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- instr  input  DATA_WIDTH  contents of the instruction register (IR)
- zero  input  1  ALU zero flag (combinational, current cycle)
- mem_ready  input  1  memory has completed the current access this cycle
- mem_req  output  1  memory access request
- mem_write  output  1  access is a write (valid only while mem_req=1)
- adr_src  output  1  memory address select: 0=PC, 1=ALUOut
- ir_write  output  1  load IR and OldPC
- pc_write  output  1  load PC from Result
- reg_write  output  1  register-file write enable
- alu_src_a  output  2  ALU A select: 00=PC, 01=OldPC, 10=rs1 register A
- alu_src_b  output  2  ALU B select: 00=rs2 register B, 01=Imm, 10=constant 4
- alu_ctrl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  output  2  00 I, 01 S, 10 B, 11 J
- result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
- illegal  output  1  sticky unsupported-instruction flag
- instret  output  DATA_WIDTH  retired-instruction counter

Behaviour:
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- rst_n low forces state RESET, illegal=0 and instret=0 asynchronously.
- In RESET all outputs are 0. RESET moves to FETCH on the first clk edge after rst_n deasserts.
- Default for every output in every state is 0 unless listed below.
- Outputs are Moore decodes of the state, except:
  - ir_write and pc_write in FETCH are qualified by mem_ready.
  - pc_write in BRANCH is qualified by the branch condition.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=add, result_src=10.
  - Stays in FETCH while mem_ready=0; mem_req stays high with address stable.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_ctrl=add.
  - imm_src=11 if opcode is JAL, else 10 (precomputes the branch/jump target into ALUOut).
  - Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other opcode -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, add. imm_src=00 for lw (next MEMREAD), 01 for sw (next MEMWRITE).
- MEMREAD: mem_req=1, adr_src=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, result_src=01, next FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Waits for mem_ready, then goes to FETCH.
- EXECR / EXECI:
  - EXECR: alu_src_a=10, alu_src_b=00. EXECI: alu_src_a=10, alu_src_b=01, imm_src=00.
  - alu_ctrl by funct3: 000 add; 111 and; 110 or; 010 slt.
  - EXECR with funct7[5]=1 and funct3=000 selects sub. EXECI ignores funct7.
  - Any other funct3/funct7 combination -> TRAP. Legal cases go to ALUWB.
- ALUWB: reg_write=1, result_src=00, next FETCH.
- BRANCH:
  - alu_src_a=10, alu_src_b=00, sub, result_src=00.
  - funct3 000 (beq): pc_write=zero. funct3 001 (bne): pc_write=~zero. Other funct3 -> TRAP with pc_write=0.
  - Next FETCH.
- JAL: pc_write=1, result_src=00, alu_src_a=01, alu_src_b=10, add (ALUOut <= OldPC+4). Next ALUWB.
- TRAP: all enables 0, illegal=1. TRAP is terminal until reset.
- instret increments by 1, wrapping at 2^DATA_WIDTH, on the final cycle of each legal instruction:
  - MEMWB, MEMWRITE completion (mem_ready=1), ALUWB, BRANCH.
  - JAL counts once, in its ALUWB.
- Latency with mem_ready tied high: R/I 4 cycles, lw 5, sw 4, branch 3, jal 4. Each cycle of mem_ready=0 adds one cycle.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum
  - opcode constants
  - alu_ctrl, imm_src, alu_src_a/b and result_src encodings
- One sub-module, alu_decoder (combinational): maps opcode class, funct3 and funct7[5] to alu_ctrl plus a legal bit.

Test Plan:
- Reset mid-MEMREAD (rst_n low at cycle 2 of a stalled lw) -> all outputs 0 immediately; instret=0; FETCH on the first edge after release.
- addi x1,x0,5 (0x00500093), mem_ready=1 -> states FETCH, DECODE, EXECI, ALUWB; reg_write only in cycle 4; alu_ctrl=000; instret 0->1.
- lw with mem_ready low for 3 cycles in both FETCH and MEMREAD -> mem_req held continuously; ir_write only on the ready cycle; total 11 cycles; reg_write with result_src=01.
- bne (funct3 001) with zero=0, then zero=1 -> pc_write=1 in BRANCH, then pc_write=0; both take 3 cycles; instret +2.
- jal x1 -> DECODE drives imm_src=11; JAL state has pc_write=1 and result_src=00; ALUWB writes rd; instret +1.
- Opcode 0x7F, and R-type funct3=001 -> TRAP; illegal=1 and stays set; no further mem_req until reset.
